// File: rtl/pipelined_addsub_pkg.sv
// rtl/pipelined_addsub_pkg.sv - stage-count and slice-geometry helpers for pipelined_addsub
package pipelined_addsub_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_CHUNK = 8;

   function automatic int num_stages(input int width, input int chunk);
      return (width + chunk - 1) / chunk;
   endfunction

   function automatic int slice_lo(input int chunk, input int k);
      return k * chunk;
   endfunction

   // Every slice is CHUNK bits except the top one, which takes what is left.
   function automatic int slice_width(input int width, input int chunk, input int k);
      int last;
      last = num_stages(width, chunk) - 1;
      return (k == last) ? (width - last * chunk) : chunk;
   endfunction

endpackage

// File: rtl/addsub_slice_stage.sv
// rtl/addsub_slice_stage.sv - one pipeline stage: registers a beat and resolves result bits [HI:LO]
module addsub_slice_stage
   import pipelined_addsub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int LO    = 0,
   parameter int HI    = DEFAULT_CHUNK - 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [WIDTH-1:0] i_sum,
   input  logic             i_carry,
   input  logic             i_next_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_a,
   output logic [WIDTH-1:0] o_b,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_carry
);

   localparam int W = HI - LO + 1;

   logic             r_valid;
   logic             r_carry;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic [W:0]       w_slice;

   assign o_ready = !r_valid || i_next_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
      end else if (o_ready) begin
         r_valid <= i_valid;
      end
   end

   // Payload needs no reset: it is only ever observed qualified by r_valid.
   always_ff @(posedge clk) begin
      if (o_ready && i_valid) begin
         r_a     <= i_a;
         r_b     <= i_b;
         r_sum   <= i_sum;
         r_carry <= i_carry;
      end
   end

   assign w_slice = {1'b0, r_a[HI:LO]} + {1'b0, r_b[HI:LO]} + {{W{1'b0}}, r_carry};

   always_comb begin
      o_sum        = r_sum;
      o_sum[HI:LO] = w_slice[W-1:0];
   end

   assign o_valid = r_valid;
   assign o_a     = r_a;
   assign o_b     = r_b;
   assign o_carry = w_slice[W];

endmodule

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - pipelined WIDTH-bit add/subtract, CHUNK bits per stage, valid/ready on both sides
module pipelined_addsub
   import pipelined_addsub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CHUNK = DEFAULT_CHUNK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   localparam int STAGES = num_stages(WIDTH, CHUNK);

   // Index 0 is the (inverted) input beat; index k+1 is what stage k hands onward.
   logic [WIDTH-1:0]  w_a   [0:STAGES];
   logic [WIDTH-1:0]  w_b   [0:STAGES];
   logic [WIDTH-1:0]  w_s   [0:STAGES];
   logic [STAGES:0]   w_c;
   logic [STAGES:0]   w_v;
   logic [STAGES-1:0] w_rdy;
   logic [STAGES-1:0] w_nready;
   logic              w_out_adv;
   logic              w_ovf;
   logic              w_unused;

   logic             r_out_valid;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_ovf;

   assign w_out_adv = !r_out_valid || out_ready;

   // Subtract is a + ~b + ~cin; after capture the stages only ever add.
   assign w_a[0] = a;
   assign w_b[0] = sub ? ~b : b;
   assign w_s[0] = '0;
   assign w_c[0] = cin ^ sub;
   assign w_v[0] = in_valid;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO = slice_lo(CHUNK, k);
      localparam int HI = LO + slice_width(WIDTH, CHUNK, k) - 1;

      // Ready is derived from registered valids directly, so there is no combinational chain.
      if (k == STAGES - 1) begin : g_last
         assign w_nready[k] = w_out_adv;
      end else begin : g_mid
         assign w_nready[k] = w_out_adv || !(&w_v[STAGES:k+2]);
      end

      addsub_slice_stage #(
         .WIDTH (WIDTH),
         .LO    (LO),
         .HI    (HI)
      ) u_stage (
         .clk          (clk),
         .rst          (rst),
         .i_valid      (w_v[k]),
         .o_ready      (w_rdy[k]),
         .i_a          (w_a[k]),
         .i_b          (w_b[k]),
         .i_sum        (w_s[k]),
         .i_carry      (w_c[k]),
         .i_next_ready (w_nready[k]),
         .o_valid      (w_v[k+1]),
         .o_a          (w_a[k+1]),
         .o_b          (w_b[k+1]),
         .o_sum        (w_s[k+1]),
         .o_carry      (w_c[k+1])
      );
   end

   assign in_ready = w_rdy[0];

   assign w_ovf = (w_a[STAGES][WIDTH-1] == w_b[STAGES][WIDTH-1]) &&
                  (w_s[STAGES][WIDTH-1] != w_a[STAGES][WIDTH-1]);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_sum       <= '0;
         r_carry     <= 1'b0;
         r_ovf       <= 1'b0;
      end else if (w_out_adv) begin
         r_out_valid <= w_v[STAGES];
         if (w_v[STAGES]) begin
            r_sum   <= w_s[STAGES];
            r_carry <= w_c[STAGES];
            r_ovf   <= w_ovf;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign sum       = r_sum;
   assign carry     = r_carry;
   assign overflow  = r_ovf;

   assign w_unused = ^{w_rdy, w_a[STAGES], w_b[STAGES]};

endmodule
